// File: rtl/stk_pkg.sv
// Shared types for the stack engine command path.
//   opcode_t  : 2-bit stack opcode (NOP/PUSH/POP/PUSHPOP)
//   req_t     : packed {opcode, data} request/command payload
//   is_rsp_op : true for opcodes that produce a response
package stk_pkg;

    localparam int unsigned DAT_W          = 128;
    localparam int unsigned ERR_W          = 2;
    localparam int unsigned ERR_ACK_NOP_B  = 0;
    localparam int unsigned ERR_RSP_MISS_B = 1;

    typedef enum logic [1:0] {
        NOP     = 2'b00,
        PUSH    = 2'b01,
        POP     = 2'b10,
        PUSHPOP = 2'b11
    } opcode_t;

    typedef struct packed {
        opcode_t            opcode;
        logic [DAT_W-1:0]   dat;
    } req_t;

    function automatic logic is_rsp_op(input opcode_t op);
        return (op == POP) || (op == PUSHPOP);
    endfunction

endpackage

// File: rtl/stk_cmd_issue_fifo.sv
// Request FIFO for stk_cmd_issue. The head entry stays in the FIFO while it is
// presented downstream and is removed on pop.
//   clk, rst     : clock, synchronous active-high reset
//   push/push_dat: write one entry (ignored when not ready)
//   pop          : remove the head entry (ignored when empty)
//   head_nxt_c   : combinational view of the head after this cycle's push/pop,
//                  all-zero (NOP) when the FIFO will be empty
//   ready        : registered not-full flag
//   empty        : registered empty flag
module stk_cmd_issue_fifo
    import stk_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t push_dat,
    input  logic pop,
    output req_t head_nxt_c,
    output logic ready,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    req_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;

    // Pointer advance; the extra MSB separates full from empty.
    always_comb begin
        do_push    = push && ready;
        do_pop     = pop && !empty;
        wr_ptr_nxt = wr_ptr + PW'(do_push);
        rd_ptr_nxt = rd_ptr + PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            ready  <= !((wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]));
        end
    end

    // Storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Next head: if it sits at the slot being written now, bypass the write data.
    always_comb begin
        head_nxt_c = '0;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (rd_ptr_nxt == wr_ptr) begin
                head_nxt_c = push_dat;
            end else begin
                head_nxt_c = mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/stk_cmd_issue.sv
// Per-engine command initiator for the stack engine. Queues host requests,
// presents the head on the command lanes until acked, and collects responses
// for response-bearing commands a fixed RSP_LAT cycles after their ack.
// Optional performance counters are enabled with STK_CMD_ISSUE_PERF_EN.
//   clk, rst                    : clock, synchronous active-high reset
//   i_req_vld/opcode/dat        : host request; o_req_rdy registered not-full
//   o_cmd_opcode/dat, i_cmd_ack : command lanes to the stack pipe
//   i_rsp_vld/dat               : shared response bus
//   o_rsp_vld/dat               : this engine's response (1-cycle pulse, data held)
//   o_err                       : sticky [0] ack while NOP, [1] missing response
//   o_perf_issued/stall         : saturating counters, zero when disabled
module stk_cmd_issue
    import stk_pkg::*;
#(
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned RSP_LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_vld,
    input  opcode_t           i_req_opcode,
    input  logic [DAT_W-1:0]  i_req_dat,
    output logic              o_req_rdy,
    output opcode_t           o_cmd_opcode,
    output logic [DAT_W-1:0]  o_cmd_dat,
    input  logic              i_cmd_ack,
    input  logic              i_rsp_vld,
    input  logic [DAT_W-1:0]  i_rsp_dat,
    output logic              o_rsp_vld,
    output logic [DAT_W-1:0]  o_rsp_dat,
    output logic [ERR_W-1:0]  o_err,
    output logic [31:0]       o_perf_issued,
    output logic [31:0]       o_perf_stall
);

    req_t               req_in;
    req_t               head_nxt_c;
    req_t               cmd_q;
    logic               fifo_empty;
    logic               fifo_push;
    logic               cmd_vld;
    logic               cmd_pop;
    logic               ack_rsp;
    logic [RSP_LAT-1:0] due_q;
    logic [RSP_LAT-1:0] due_nxt;
    logic [ERR_W-1:0]   err_q;

    // NOP requests are accepted but never stored.
    always_comb begin
        req_in.opcode = i_req_opcode;
        req_in.dat    = i_req_dat;
        fifo_push     = i_req_vld && o_req_rdy && (i_req_opcode != NOP);
        cmd_vld       = (cmd_q.opcode != NOP);
        cmd_pop       = i_cmd_ack && !fifo_empty;
        ack_rsp       = cmd_pop && is_rsp_op(cmd_q.opcode);
        // Bit 0 of due_q marks the cycle a response is expected on the bus.
        due_nxt       = (due_q >> 1) | (RSP_LAT'(ack_rsp) << (RSP_LAT - 1));
    end

    stk_cmd_issue_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_dat   (req_in),
        .pop        (cmd_pop),
        .head_nxt_c (head_nxt_c),
        .ready      (o_req_rdy),
        .empty      (fifo_empty)
    );

    // Command presentation, response capture and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            due_q     <= '0;
            o_rsp_vld <= 1'b0;
            o_rsp_dat <= '0;
            err_q     <= '0;
        end else begin
            cmd_q     <= head_nxt_c;
            due_q     <= due_nxt;
            o_rsp_vld <= due_q[0] && i_rsp_vld;
            if (due_q[0] && i_rsp_vld) begin
                o_rsp_dat <= i_rsp_dat;
            end
            if (i_cmd_ack && !cmd_vld) begin
                err_q[ERR_ACK_NOP_B] <= 1'b1;
            end
            if (due_q[0] && !i_rsp_vld) begin
                err_q[ERR_RSP_MISS_B] <= 1'b1;
            end
        end
    end

    assign o_cmd_opcode = cmd_q.opcode;
    assign o_cmd_dat    = cmd_q.dat;
    assign o_err        = err_q;

`ifdef STK_CMD_ISSUE_PERF_EN
    logic [31:0] issued_q;
    logic [31:0] stall_q;

    // Saturating issue/stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (cmd_vld && i_cmd_ack && (issued_q != '1)) begin
                issued_q <= issued_q + 32'd1;
            end
            if (cmd_vld && !i_cmd_ack && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign o_perf_issued = issued_q;
    assign o_perf_stall  = stall_q;
`else
    assign o_perf_issued = '0;
    assign o_perf_stall  = '0;
`endif

endmodule

// File: tb/tb_stk_cmd_issue.sv
// Directed bench for stk_cmd_issue with a scoreboard: expected commands and
// responses are queued as stimulus is issued and checked by a negedge monitor.
module tb_stk_cmd_issue;
    import stk_pkg::*;

    logic          clk;
    logic          rst;
    logic          i_req_vld;
    opcode_t       i_req_opcode;
    logic [127:0]  i_req_dat;
    logic          o_req_rdy;
    opcode_t       o_cmd_opcode;
    logic [127:0]  o_cmd_dat;
    logic          i_cmd_ack;
    logic          i_rsp_vld;
    logic [127:0]  i_rsp_dat;
    logic          o_rsp_vld;
    logic [127:0]  o_rsp_dat;
    logic [1:0]    o_err;
    logic [31:0]   o_perf_issued;
    logic [31:0]   o_perf_stall;

    int checks = 0;
    int errors = 0;

    req_t         cmd_exp[$];
    logic [127:0] rsp_exp[$];

    stk_cmd_issue #(.REQ_DEPTH(4), .RSP_LAT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_vld     (i_req_vld),
        .i_req_opcode  (i_req_opcode),
        .i_req_dat     (i_req_dat),
        .o_req_rdy     (o_req_rdy),
        .o_cmd_opcode  (o_cmd_opcode),
        .o_cmd_dat     (o_cmd_dat),
        .i_cmd_ack     (i_cmd_ack),
        .i_rsp_vld     (i_rsp_vld),
        .i_rsp_dat     (i_rsp_dat),
        .o_rsp_vld     (o_rsp_vld),
        .o_rsp_dat     (o_rsp_dat),
        .o_err         (o_err),
        .o_perf_issued (o_perf_issued),
        .o_perf_stall  (o_perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        i_req_vld = 1'b0;
        i_cmd_ack = 1'b0;
        i_rsp_vld = 1'b0;
        step();
        step();
        rst = 1'b0;
        cmd_exp.delete();
        rsp_exp.delete();
    endtask

    task automatic push_req(input opcode_t op, input logic [127:0] dat);
        req_t e;
        i_req_vld    = 1'b1;
        i_req_opcode = op;
        i_req_dat    = dat;
        e.opcode     = op;
        e.dat        = dat;
        if (op != NOP) cmd_exp.push_back(e);
    endtask

    // Monitor: accepted commands and produced responses against the scoreboard.
    always @(negedge clk) begin
        req_t         e;
        logic [127:0] r;
        if (!rst && i_cmd_ack && (o_cmd_opcode != NOP)) begin
            if (cmd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got op %0d dat %0h expected none", o_cmd_opcode, o_cmd_dat);
            end else begin
                e = cmd_exp.pop_front();
                chk("cmd_op", 128'(o_cmd_opcode), 128'(e.opcode));
                chk("cmd_dat", o_cmd_dat, e.dat);
            end
        end
        if (o_rsp_vld) begin
            if (rsp_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got dat %0h expected no response", o_rsp_dat);
            end else begin
                r = rsp_exp.pop_front();
                chk("rsp_dat", o_rsp_dat, r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        i_req_opcode = NOP;
        i_req_dat    = '0;
        i_rsp_dat    = '0;
        do_reset();

        // Reset state
        chk("rst_rdy", 128'(o_req_rdy), 128'(1));
        chk("rst_cmd_op", 128'(o_cmd_opcode), 128'(NOP));
        chk("rst_cmd_dat", o_cmd_dat, 128'h0);
        chk("rst_rsp_vld", 128'(o_rsp_vld), 128'(0));
        chk("rst_rsp_dat", o_rsp_dat, 128'h0);
        chk("rst_err", 128'(o_err), 128'(0));
        chk("rst_perf_issued", 128'(o_perf_issued), 128'(0));
        chk("rst_perf_stall", 128'(o_perf_stall), 128'(0));

        // Single PUSH: presented cycles 1..3, acked at 3, NOP at 4
        push_req(PUSH, 128'hA5);
        step();
        i_req_vld = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            chk("t1_op_stable", 128'(o_cmd_opcode), 128'(PUSH));
            chk("t1_dat_stable", o_cmd_dat, 128'hA5);
            if (t == 3) i_cmd_ack = 1'b1;
            step();
        end
        i_cmd_ack = 1'b0;
        chk("t1_nop_after", 128'(o_cmd_opcode), 128'(NOP));
        chk("t1_err", 128'(o_err), 128'(0));
`ifdef STK_CMD_ISSUE_PERF_EN
        chk("t1_perf_issued", 128'(o_perf_issued), 128'(1));
        chk("t1_perf_stall", 128'(o_perf_stall), 128'(2));
`else
        chk("t1_perf_issued", 128'(o_perf_issued), 128'(0));
        chk("t1_perf_stall", 128'(o_perf_stall), 128'(0));
`endif
        step();
        step();

        // POP response: ack at T=1, bus response at T+3, output at T+4
        do_reset();
        push_req(POP, 128'h77);
        step();
        i_req_vld = 1'b0;
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        step();
        step();
        i_rsp_vld = 1'b1;
        i_rsp_dat = 128'h1234;
        rsp_exp.push_back(128'h1234);
        chk("t2_no_early_rsp", 128'(o_rsp_vld), 128'(0));
        step();
        i_rsp_vld = 1'b0;
        chk("t2_rsp_vld", 128'(o_rsp_vld), 128'(1));
        chk("t2_rsp_dat", o_rsp_dat, 128'h1234);
        chk("t2_err", 128'(o_err), 128'(0));
        step();
        chk("t2_rsp_pulse", 128'(o_rsp_vld), 128'(0));
        chk("t2_rsp_hold", o_rsp_dat, 128'h1234);

        // Pipelined: POPs acked at cycles 1,2,3; responses 1,2,3 at 4,5,6
        do_reset();
        push_req(POP, 128'h10);
        step();
        push_req(POP, 128'h11);
        i_cmd_ack = 1'b1;
        step();
        push_req(POP, 128'h12);
        step();
        i_req_vld = 1'b0;
        step();
        i_cmd_ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            i_rsp_vld = 1'b1;
            i_rsp_dat = 128'(k);
            rsp_exp.push_back(128'(k));
            if (k > 1) chk("t3_rsp_dat", o_rsp_dat, 128'(k - 1));
            step();
        end
        i_rsp_vld = 1'b0;
        chk("t3_rsp_vld_last", 128'(o_rsp_vld), 128'(1));
        chk("t3_rsp_dat_last", o_rsp_dat, 128'h3);
        step();
        chk("t3_rsp_idle", 128'(o_rsp_vld), 128'(0));
        chk("t3_err", 128'(o_err), 128'(0));

        // Full FIFO, then ack with a simultaneous (rejected) push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("t4_rdy_fill", 128'(o_req_rdy), 128'(1));
            push_req(PUSH, 128'(32'h100 + i));
            step();
        end
        chk("t4_rdy_full", 128'(o_req_rdy), 128'(0));
        i_req_vld    = 1'b1;
        i_req_opcode = PUSH;
        i_req_dat    = 128'hBAD;
        i_cmd_ack    = 1'b1;
        step();
        i_req_vld = 1'b0;
        chk("t4_rdy_after_ack", 128'(o_req_rdy), 128'(1));
        step();
        step();
        step();
        i_cmd_ack = 1'b0;
        chk("t4_drained", 128'(o_cmd_opcode), 128'(NOP));
        push_req(NOP, 128'hDEAD);
        step();
        i_req_vld = 1'b0;
        chk("t4_nop_dropped", 128'(o_cmd_opcode), 128'(NOP));
        chk("t4_nop_rdy", 128'(o_req_rdy), 128'(1));

        // Errors: ack while idle, missing response, foreign response
        do_reset();
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        chk("t5_err_ack_nop", 128'(o_err), 128'(2'b01));
        push_req(POP, 128'h55);
        step();
        i_req_vld = 1'b0;
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        step();
        step();
        step();
        chk("t5_err_miss", 128'(o_err), 128'(2'b11));
        chk("t5_no_rsp", 128'(o_rsp_vld), 128'(0));
        i_rsp_vld = 1'b1;
        i_rsp_dat = 128'hF00;
        step();
        i_rsp_vld = 1'b0;
        chk("t5_foreign_ignored", 128'(o_rsp_vld), 128'(0));
        chk("t5_err_sticky", 128'(o_err), 128'(2'b11));

        // Reset mid-flight: POP acked at T, rst at T+1, response at T+3
        do_reset();
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        push_req(POP, 128'h66);
        step();
        push_req(PUSH, 128'h67);
        i_cmd_ack = 1'b1;
        step();
        i_req_vld = 1'b0;
        i_cmd_ack = 1'b0;
        chk("t6_pre_err", 128'(o_err), 128'(2'b01));
        chk("t6_pre_cmd", 128'(o_cmd_opcode), 128'(PUSH));
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd_exp.delete();
        step();
        i_rsp_vld = 1'b1;
        i_rsp_dat = 128'h999;
        step();
        i_rsp_vld = 1'b0;
        chk("t6_no_rsp", 128'(o_rsp_vld), 128'(0));
        chk("t6_cmd_nop", 128'(o_cmd_opcode), 128'(NOP));
        chk("t6_err_clr", 128'(o_err), 128'(0));
        chk("t6_rdy", 128'(o_req_rdy), 128'(1));
        chk("t6_perf_issued", 128'(o_perf_issued), 128'(0));
        chk("t6_perf_stall", 128'(o_perf_stall), 128'(0));
        step();
        chk("t6_no_rsp_late", 128'(o_rsp_vld), 128'(0));

        chk("cmd_scoreboard_empty", 128'(cmd_exp.size()), 128'(0));
        chk("rsp_scoreboard_empty", 128'(rsp_exp.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
